// File: rtl/counter_mod_if.sv
// Control/data bundle for counter_mod: load/count controls in, count and
// boundary flags out. The master drives controls, the counter is the slave.
interface counter_mod_if #(
  parameter int unsigned WORD_WIDTH = 8
);
  logic                  load_i;
  logic                  count_i;
  logic                  dir_i;
  logic                  sat_i;
  logic [WORD_WIDTH-1:0] step_i;
  logic [WORD_WIDTH-1:0] data_i;
  logic [WORD_WIDTH-1:0] data_o;
  logic                  will_overflow_o;
  logic                  overflow_o;
  logic                  at_max_o;
  logic                  at_zero_o;

  // No valid/ready pair: every control is sampled at each rising clk edge,
  // priority reset > load > count > hold; outputs are valid every cycle.
  modport master (
    output load_i, count_i, dir_i, sat_i, step_i, data_i,
    input  data_o, will_overflow_o, overflow_o, at_max_o, at_zero_o
  );

  modport slave (
    input  load_i, count_i, dir_i, sat_i, step_i, data_i,
    output data_o, will_overflow_o, overflow_o, at_max_o, at_zero_o
  );
endinterface

// File: rtl/counter_mod.sv
// Modulo up/down counter with variable step, wrap or saturate at the ends,
// a combinational look-ahead crossing flag and a registered crossing pulse.
module counter_mod #(
  parameter int unsigned     WORD_WIDTH  = 8,
  parameter longint unsigned MODULUS     = 0,
  parameter longint unsigned RESET_VALUE = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  counter_mod_if.slave  bus
);

  localparam longint unsigned MAX_L =
    (MODULUS == 0) ? ((64'd1 << WORD_WIDTH) - 64'd1) : (MODULUS - 64'd1);

  localparam logic [WORD_WIDTH:0]   MAX_EXT   = (WORD_WIDTH+1)'(MAX_L);
  localparam logic [WORD_WIDTH:0]   RANGE_EXT = MAX_EXT + 1'b1;
  localparam logic [WORD_WIDTH-1:0] MAX_W     = WORD_WIDTH'(MAX_L);
  localparam logic [WORD_WIDTH-1:0] RESET_W   = WORD_WIDTH'(RESET_VALUE);

  if (WORD_WIDTH < 2) begin : g_bad_width
    $error("counter_mod: WORD_WIDTH must be at least 2");
  end
  if (MODULUS != 0 && (MODULUS < 2 || MODULUS > (64'd1 << WORD_WIDTH))) begin : g_bad_modulus
    $error("counter_mod: MODULUS must be 0 or within 2..2**WORD_WIDTH");
  end
  if (RESET_VALUE > MAX_L) begin : g_bad_reset
    $error("counter_mod: RESET_VALUE exceeds the counter maximum");
  end

  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  overflow_q;

  logic [WORD_WIDTH:0]   data_ext;
  logic [WORD_WIDTH:0]   step_ext;
  logic [WORD_WIDTH:0]   step_eff;
  logic [WORD_WIDTH:0]   load_ext;
  logic [WORD_WIDTH:0]   sum_up;
  logic                  up_cross;
  logic                  down_cross;
  logic                  crossing;
  logic [WORD_WIDTH-1:0] up_next;
  logic [WORD_WIDTH-1:0] down_next;
  logic [WORD_WIDTH-1:0] load_val;
  logic                  will_overflow;

  // One extra bit of headroom keeps data + step and data + range exact.
  always_comb begin
    data_ext   = {1'b0, data_q};
    step_ext   = {1'b0, bus.step_i};
    load_ext   = {1'b0, bus.data_i};
    step_eff   = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
    sum_up     = data_ext + step_eff;
    up_cross   = (sum_up > MAX_EXT);
    down_cross = (data_ext < step_eff);
    crossing   = (step_eff != '0) && (bus.dir_i ? down_cross : up_cross);
    load_val   = (load_ext > MAX_EXT) ? MAX_W : bus.data_i;
  end

  always_comb begin
    up_next = sum_up[WORD_WIDTH-1:0];
    if (up_cross) begin
      up_next = bus.sat_i ? MAX_W : WORD_WIDTH'(sum_up - RANGE_EXT);
    end
  end

  always_comb begin
    down_next = WORD_WIDTH'(data_ext - step_eff);
    if (down_cross) begin
      down_next = bus.sat_i ? '0 : WORD_WIDTH'(data_ext + RANGE_EXT - step_eff);
    end
  end

  always_comb begin
    data_d = data_q;
    if (bus.load_i) begin
      data_d = load_val;
    end else if (bus.count_i) begin
      data_d = bus.dir_i ? down_next : up_next;
    end
  end

  assign will_overflow = !rst_i && !bus.load_i && bus.count_i && crossing;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q     <= RESET_W;
      overflow_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      overflow_q <= will_overflow;
    end
  end

  assign bus.data_o          = data_q;
  assign bus.will_overflow_o = will_overflow;
  assign bus.overflow_o      = overflow_q;
  assign bus.at_max_o        = (data_q == MAX_W);
  assign bus.at_zero_o       = (data_q == '0);

endmodule

// File: tb/tb_counter_mod.sv
// Bench for counter_mod: a MODULUS=10 and a MODULUS=0 instance share one
// stimulus stream and are compared against an integer model of the counter.
module tb_counter_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       count = 1'b0;
  logic       dir = 1'b0;
  logic       sat = 1'b0;
  logic [3:0] step = 4'd0;
  logic [3:0] data = 4'd0;

  int n_pass = 0;
  int n_total = 0;
  int ma = 0;
  int mb = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  counter_mod_if #(.WORD_WIDTH(4)) bus_a ();
  counter_mod_if #(.WORD_WIDTH(4)) bus_b ();

  assign bus_a.load_i = load;  assign bus_b.load_i = load;
  assign bus_a.count_i = count; assign bus_b.count_i = count;
  assign bus_a.dir_i = dir;    assign bus_b.dir_i = dir;
  assign bus_a.sat_i = sat;    assign bus_b.sat_i = sat;
  assign bus_a.step_i = step;  assign bus_b.step_i = step;
  assign bus_a.data_i = data;  assign bus_b.data_i = data;

  counter_mod #(.WORD_WIDTH(4), .MODULUS(10), .RESET_VALUE(3)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a.slave)
  );
  counter_mod #(.WORD_WIDTH(4), .MODULUS(0), .RESET_VALUE(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b.slave)
  );

  // Counter behaviour on plain integers: range 0..m-1, reset value 3.
  function automatic void model(input int m, input int cur, input bit r, input bit l,
                                input bit c, input bit d, input bit s, input int st,
                                input int dt, output int nxt, output bit wov);
    int mx, se, t;
    mx  = m - 1;
    se  = (st > mx) ? mx : st;
    wov = 1'b0;
    nxt = cur;
    if (r) nxt = 3;
    else if (l) nxt = (dt > mx) ? mx : dt;
    else if (c && se != 0) begin
      t = d ? cur - se : cur + se;
      if (t > mx) begin
        wov = 1'b1;
        nxt = s ? mx : t - m;
      end else if (t < 0) begin
        wov = 1'b1;
        nxt = s ? 0 : t + m;
      end else nxt = t;
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input bit r, input bit l, input bit c, input bit d, input bit s,
                      input int st, input int dt);
    int na, nb;
    bit wa, wb;
    @(negedge clk);
    rst = r; load = l; count = c; dir = d; sat = s;
    step = st[3:0]; data = dt[3:0];
    #1;
    model(10, ma, r, l, c, d, s, st, dt, na, wa);
    model(16, mb, r, l, c, d, s, st, dt, nb, wb);
    chk("will_ov_a", 8'(bus_a.will_overflow_o), 8'(wa));
    chk("will_ov_b", 8'(bus_b.will_overflow_o), 8'(wb));
    exp_q.push_back(na[3:0]);
    exp_q.push_back(nb[3:0]);
    @(posedge clk);
    #1;
    ma = na;
    mb = nb;
    chk("data_a", 8'(bus_a.data_o), 8'(exp_q.pop_front()));
    chk("data_b", 8'(bus_b.data_o), 8'(exp_q.pop_front()));
    chk("ov_a", 8'(bus_a.overflow_o), 8'(wa));
    chk("ov_b", 8'(bus_b.overflow_o), 8'(wb));
    chk("at_max_a", 8'(bus_a.at_max_o), 8'(ma == 9));
    chk("at_max_b", 8'(bus_b.at_max_o), 8'(mb == 15));
    chk("at_zero_a", 8'(bus_a.at_zero_o), 8'(ma == 0));
    chk("at_zero_b", 8'(bus_b.at_zero_o), 8'(mb == 0));
  endtask

  initial begin
    // reset and clamped load
    tick(1, 0, 0, 0, 0, 0, 0);
    chk("reset_val", 8'(bus_a.data_o), 8'd3);
    chk("reset_ov", 8'(bus_a.overflow_o), 8'd0);
    tick(0, 1, 0, 0, 0, 0, 6);
    chk("load6", 8'(bus_a.data_o), 8'd6);
    tick(0, 1, 0, 0, 0, 0, 12);
    chk("load12_clamp", 8'(bus_a.data_o), 8'd9);
    chk("load12_max", 8'(bus_a.at_max_o), 8'd1);

    // up wrap
    tick(0, 1, 0, 0, 0, 0, 7);
    tick(0, 0, 1, 0, 0, 1, 0);
    chk("up_8", 8'(bus_a.data_o), 8'd8);
    tick(0, 0, 1, 0, 0, 1, 0);
    chk("up_9", 8'(bus_a.data_o), 8'd9);
    chk("up_9_wov", 8'(bus_a.will_overflow_o), 8'd1);
    tick(0, 0, 1, 0, 0, 1, 0);
    chk("up_wrap0", 8'(bus_a.data_o), 8'd0);
    chk("up_wrap_ov", 8'(bus_a.overflow_o), 8'd1);
    tick(0, 0, 1, 0, 0, 1, 0);
    chk("up_1", 8'(bus_a.data_o), 8'd1);
    chk("up_1_ov", 8'(bus_a.overflow_o), 8'd0);

    // down wrap with step, step clamp
    tick(0, 1, 0, 0, 0, 0, 2);
    tick(0, 0, 1, 1, 0, 5, 0);
    chk("down_wrap7", 8'(bus_a.data_o), 8'd7);
    chk("down_wrap_ov", 8'(bus_a.overflow_o), 8'd1);
    tick(0, 0, 1, 1, 0, 5, 0);
    chk("down_2", 8'(bus_a.data_o), 8'd2);
    chk("down_2_ov", 8'(bus_a.overflow_o), 8'd0);
    tick(0, 0, 1, 1, 0, 15, 0);
    chk("down_clamp3", 8'(bus_a.data_o), 8'd3);

    // saturate
    tick(0, 1, 0, 0, 1, 0, 8);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 0, 1, 3, 0);
      chk("sat_hi", 8'(bus_a.data_o), 8'd9);
      chk("sat_hi_ov", 8'(bus_a.overflow_o), 8'd1);
    end
    tick(0, 1, 0, 0, 1, 0, 1);
    tick(0, 0, 1, 1, 1, 3, 0);
    chk("sat_lo", 8'(bus_a.data_o), 8'd0);
    chk("sat_lo_ov", 8'(bus_a.overflow_o), 8'd1);

    // priority and zero step
    tick(0, 1, 0, 0, 0, 0, 9);
    tick(0, 1, 1, 0, 0, 1, 4);
    chk("prio_load", 8'(bus_a.data_o), 8'd4);
    chk("prio_ov", 8'(bus_a.overflow_o), 8'd0);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("step0_hold", 8'(bus_a.data_o), 8'd4);
    chk("step0_ov", 8'(bus_a.overflow_o), 8'd0);

    // reset mid-operation, then MODULUS=0 wrap
    tick(0, 1, 0, 0, 0, 0, 9);
    @(negedge clk);
    count = 1'b1; step = 4'd1; dir = 1'b0; sat = 1'b0; load = 1'b0;
    #1;
    chk("pre_rst_wov", 8'(bus_a.will_overflow_o), 8'd1);
    tick(1, 1, 1, 0, 0, 1, 5);
    chk("rst_mid_val", 8'(bus_a.data_o), 8'd3);
    chk("rst_mid_ov", 8'(bus_a.overflow_o), 8'd0);
    tick(0, 1, 0, 0, 0, 0, 15);
    chk("mod0_load15", 8'(bus_b.data_o), 8'd15);
    tick(0, 0, 1, 0, 0, 1, 0);
    chk("mod0_wrap", 8'(bus_b.data_o), 8'd0);
    chk("mod0_ov", 8'(bus_b.overflow_o), 8'd1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter_mod.md
Name: counter_mod

Overview:
- Parametrised successor of the basic load/count counter. Adds a programmable modulus, up/down direction, a variable step, and a choice of wrap or saturate at the boundaries.
- Reports a boundary crossing combinationally one cycle ahead, and as a registered pulse when the crossing happens.
- Used as the general-purpose timer, address and loop counter in std utils. Single clock domain.

Parameters:
- WORD_WIDTH, 8, counter/data width in bits (>=2).
- MODULUS, 0, count range 0..MODULUS-1. 0 means 2^WORD_WIDTH. Must be 0 or in 2..2^WORD_WIDTH.
- RESET_VALUE, 0, value loaded on reset. Must be <= MAX.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- load_i  in  1  load data_i on next edge.
- count_i  in  1  count enable.
- dir_i  in  1  0 = up, 1 = down.
- sat_i  in  1  0 = wrap at boundaries, 1 = saturate.
- step_i  in  WORD_WIDTH  increment/decrement amount.
- data_i  in  WORD_WIDTH  load value.
- data_o  out  WORD_WIDTH  current count, registered.
- will_overflow_o  out  1  combinational: the next edge crosses a boundary.
- overflow_o  out  1  registered one-cycle pulse: the last edge crossed a boundary.
- at_max_o  out  1  combinational: data_o == MAX.
- at_zero_o  out  1  combinational: data_o == 0.

Behaviour:
- MAX = (MODULUS==0 ? 2^WORD_WIDTH-1 : MODULUS-1).
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i; no asynchronous reset path.
- Reset, sampled on the clk_i rising edge:
  - data_o <= RESET_VALUE.
  - overflow_o <= 0.
  - All other inputs are ignored that cycle.
  - rst_i asserted mid-count overrides everything at the next edge.
- Priority per edge: rst_i > load_i > count_i > hold.
- Load:
  - data_o <= min(data_i, MAX); out-of-range loads clamp to MAX.
  - overflow_o <= 0.
  - Latency 1 cycle.
- Effective step: s = min(step_i, MAX). s==0 means no change and no overflow.
- Arithmetic: done in WORD_WIDTH+1 bits; no truncation artefacts.
- Up count:
  - If data_o + s <= MAX: data_o <= data_o + s.
  - Otherwise it is a crossing. Wrap mode: data_o <= data_o + s - (MAX+1). Saturate mode: data_o <= MAX.
- Down count:
  - If data_o >= s: data_o <= data_o - s.
  - Otherwise it is a crossing. Wrap mode: data_o <= data_o + (MAX+1) - s. Saturate mode: data_o <= 0.
- Saturate at the boundary:
  - Already at MAX counting up with s>0 counts as a crossing: data_o holds and overflow_o pulses every such cycle.
  - Likewise at 0 counting down.
- will_overflow_o = !rst_i && !load_i && count_i && s!=0 && crossing condition (above) evaluated on the current data_o, dir_i, step_i. Purely combinational from inputs and state.
- overflow_o:
  - Equals will_overflow_o registered.
  - High for exactly the one cycle after a crossing edge, otherwise 0.
  - Back-to-back crossings give consecutive high cycles.
- Hold (count_i=0, no load/reset): data_o unchanged, overflow_o <= 0.
- dir_i, sat_i and step_i may change every cycle; only values sampled at the edge matter.
- Elaboration must $error on an illegal MODULUS or RESET_VALUE.

Test Plan (WORD_WIDTH=4, MODULUS=10, RESET_VALUE=3):
1. Reset and clamped load:
   - rst_i=1 for 1 edge -> data_o=3, overflow_o=0.
   - Then load_i=1, data_i=6 -> data_o=6.
   - Then load_i=1, data_i=12 -> data_o=9, at_max_o=1.
2. Up wrap:
   - Load 7, count up step 1, sat_i=0: edges give 8, 9, 0, 1.
   - will_overflow_o=1 while data_o=9.
   - overflow_o=1 only in the cycle data_o=0.
3. Down wrap with step:
   - Load 2, dir_i=1, step_i=5, sat_i=0 -> data_o=7, overflow_o pulses.
   - Next edge -> 2, no pulse.
   - step_i=15 clamps to 9: from 2 -> 3.
4. Saturate:
   - Load 8, up, step 3, sat_i=1 -> data_o=9, overflow_o=1.
   - Three more edges -> data_o stays 9, overflow_o stays 1.
   - dir_i=1 from 1, step 3 -> 0, overflow_o=1.
5. Priority and step zero:
   - load_i=1, count_i=1, data_i=4 at data_o=9 -> data_o=4, overflow_o=0, will_overflow_o=0.
   - step_i=0, count_i=1 -> data_o holds, no overflow.
6. Reset mid-operation:
   - Counting up at data_o=9 with will_overflow_o=1, assert rst_i together with load_i=1 -> data_o=3, overflow_o=0 next cycle.
   - will_overflow_o=0 while rst_i=1.
   - Repeat with MODULUS=0: 15+1 wraps to 0 with an overflow_o pulse.
